score_tracker: RTL and testbench

Game-side score bookkeeper that produces the `newHighScore` and `died` event pulses consumed by the face-display logic. It counts points during a game, keeps the session high score, and on game over emits exactly one single-cycle event: a record or a plain death. It sits between the gameplay/collision logic and the face/7-segment display path. Its held score and high score also feed the digit displays.

---
 rtl/score_pkg.sv | 16 +
 rtl/holdoff_timer.sv | 36 +++
 rtl/score_tracker.sv | 117 +++++++++++
 tb/tb_score_tracker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: definitions shared by the score_tracker block.
//   state_t             - game state encoding (IDLE, PLAYING, OVER)
//   DEF_MAX_SCORE       - default saturation value of the score counter
//   DEF_HOLD_CYCLES     - default post-game restart lockout length in clocks
package score_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        OVER    = 2'd2
    } state_t;

    localparam int DEF_MAX_SCORE   = 99;
    localparam int DEF_HOLD_CYCLES = 50_000_000;

endpackage

// File: rtl/holdoff_timer.sv
// holdoff_timer: load/count-down lockout counter.
// A pulse on `load` sets the count to HOLD_CYCLES-1; it then decrements once
// per clock until it reaches zero and stays there. `done` is high whenever
// the count is zero (including straight out of reset).
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset (count cleared to 0)
//   load  in  restart the lockout
//   done  out lockout has expired
module holdoff_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/score_tracker.sv
// score_tracker: per-game score counter and session high score keeper.
// Counts `point` pulses during a game (saturating at MAX_SCORE), and on the
// `hit` that ends the game emits exactly one single-cycle event: newHighScore
// when the score strictly beats the high score (which is then updated), died
// otherwise. The last game's score is held for display until the next start.
// Optional feature: define SCORE_TRACKER_HOLDOFF_EN to lock out restarts for
// HOLD_CYCLES clocks after a game ends, so the face display is not clipped.
// Ports:
//   clk           in  system clock
//   rst           in  asynchronous active-low reset
//   start         in  request to begin a game
//   point         in  add one point
//   hit           in  player killed, ends the game
//   score         out current or last-game score
//   highScore     out best score since reset
//   newHighScore  out one-cycle pulse: game ended with a record
//   died          out one-cycle pulse: game ended without a record
//   playing       out high while a game is in progress
module score_tracker
    import score_pkg::*;
#(
    parameter int SCORE_W     = 7,
    parameter int MAX_SCORE   = DEF_MAX_SCORE,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               point,
    input  logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] highScore,
    output logic               newHighScore,
    output logic               died,
    output logic               playing
);

    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

    generate
        if (MAX_SCORE >= (1 << SCORE_W)) begin : g_bad_max
            $error("score_tracker: MAX_SCORE does not fit in SCORE_W bits");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("score_tracker: HOLD_CYCLES must be at least 1");
        end
    endgenerate

    state_t state;
    logic   start_ok;

`ifdef SCORE_TRACKER_HOLDOFF_EN
    // Lockout starts on the same edge the game ends.
    holdoff_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_holdoff (
        .clk  (clk),
        .rst  (rst),
        .load ((state == PLAYING) && hit),
        .done (start_ok)
    );
`else
    assign start_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            score        <= '0;
            highScore    <= '0;
            newHighScore <= 1'b0;
            died         <= 1'b0;
            playing      <= 1'b0;
        end else begin
            // Event outputs are pulses: cleared unless set below.
            newHighScore <= 1'b0;
            died         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= PLAYING;
                        score   <= '0;
                        playing <= 1'b1;
                    end
                end
                PLAYING: begin
                    // hit takes priority; a simultaneous point is dropped and
                    // the comparison uses the score from before this cycle.
                    if (hit) begin
                        state   <= OVER;
                        playing <= 1'b0;
                        if (score > highScore) begin
                            highScore    <= score;
                            newHighScore <= 1'b1;
                        end else begin
                            died <= 1'b1;
                        end
                    end else if (point && (score != MAX_VAL)) begin
                        score <= score + 1'b1;
                    end
                end
                OVER: begin
                    if (start && start_ok) begin
                        state   <= PLAYING;
                        score   <= '0;
                        playing <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker. Inputs change on the falling edge and
// outputs are checked on the falling edge, half a period after the active edge.
module tb_score_tracker;

`ifdef SCORE_TRACKER_HOLDOFF_EN
    localparam int TB_HOLD = 10;
`else
    localparam int TB_HOLD = 50_000_000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start, point, hit;
    logic [6:0] score, highScore;
    logic       newHighScore, died, playing;

    int total = 0;
    int bad   = 0;

    score_tracker #(
        .SCORE_W     (7),
        .MAX_SCORE   (99),
        .HOLD_CYCLES (TB_HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .point        (point),
        .hit          (hit),
        .score        (score),
        .highScore    (highScore),
        .newHighScore (newHighScore),
        .died         (died),
        .playing      (playing)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_points(input int n);
        point = 1'b1;
        repeat (n) cyc();
        point = 1'b0;
    endtask

    // Start a new game from OVER, waiting out the lockout when it exists.
    task automatic restart(input string tag);
`ifdef SCORE_TRACKER_HOLDOFF_EN
        repeat (TB_HOLD) cyc();
`endif
        start = 1'b1;
        cyc();
        start = 1'b0;
        check({tag, "_playing"}, playing, 1);
        check({tag, "_score0"}, score, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; point = 1'b0; hit = 1'b0;
        @(negedge clk);
        repeat (2) cyc();
        check("rst_score", score, 0);
        check("rst_hs", highScore, 0);
        check("rst_nhs", newHighScore, 0);
        check("rst_died", died, 0);
        check("rst_playing", playing, 0);
        rst = 1'b1;
        cyc();

        // Game 1: 5 points, record
        start = 1'b1; cyc(); start = 1'b0;
        check("g1_playing", playing, 1);
        check("g1_score0", score, 0);
        do_points(5);
        check("g1_score5", score, 5);
        hit = 1'b1; cyc(); hit = 1'b0;
        check("g1_nhs", newHighScore, 1);
        check("g1_died", died, 0);
        check("g1_hs", highScore, 5);
        check("g1_playing_low", playing, 0);
        check("g1_score_held", score, 5);
`ifdef SCORE_TRACKER_HOLDOFF_EN
        cyc();
        check("g1_nhs_clear", newHighScore, 0);
        restart("g2");
`else
        // Restart on the very cycle the event pulse is visible.
        start = 1'b1; cyc(); start = 1'b0;
        check("g2_nhs_clear", newHighScore, 0);
        check("g2_playing", playing, 1);
        check("g2_score0", score, 0);
`endif

        // Game 2: tie -> died, hit held two cycles
        do_points(5);
        hit = 1'b1; cyc();
        check("g2_died", died, 1);
        check("g2_nhs", newHighScore, 0);
        check("g2_hs", highScore, 5);
        cyc(); hit = 1'b0;
        check("g2_died_once", died, 0);
        check("g2_nhs_none", newHighScore, 0);
        point = 1'b1; cyc(); point = 1'b0;
        check("g2_over_point_ignored", score, 5);

        // Game 3: saturation
        restart("g3");
        do_points(120);
        check("g3_sat", score, 99);
        hit = 1'b1; cyc(); hit = 1'b0;
        check("g3_nhs", newHighScore, 1);
        check("g3_died", died, 0);
        check("g3_hs", highScore, 99);
        cyc();
        check("g3_nhs_clear", newHighScore, 0);

        // Reset mid-game
        restart("g4");
        do_points(7);
        check("g4_score7", score, 7);
        rst = 1'b0;
        #1;
        check("amid_score", score, 0);
        check("amid_hs", highScore, 0);
        check("amid_playing", playing, 0);
        cyc();
        check("amid_nhs", newHighScore, 0);
        check("amid_died", died, 0);
        rst = 1'b1;
        point = 1'b1; cyc(); point = 1'b0;
        check("idle_point_ignored", score, 0);
        check("idle_not_playing", playing, 0);

        // Game 5: score 0 vs high score 0 -> died
        start = 1'b1; cyc(); start = 1'b0;
        check("g5_playing", playing, 1);
        hit = 1'b1; cyc(); hit = 1'b0;
        check("g5_died", died, 1);
        check("g5_nhs", newHighScore, 0);
        check("g5_hs", highScore, 0);

        // Game 6: 3 points, record 3
        restart("g6");
        do_points(3);
        hit = 1'b1; cyc(); hit = 1'b0;
        check("g6_nhs", newHighScore, 1);
        check("g6_hs", highScore, 3);

        // Game 7: point and hit together at score 3, high score 3
        restart("g7");
        do_points(3);
        point = 1'b1; hit = 1'b1; cyc(); point = 1'b0; hit = 1'b0;
        check("g7_score", score, 3);
        check("g7_died", died, 1);
        check("g7_nhs", newHighScore, 0);
        check("g7_hs", highScore, 3);

`ifdef SCORE_TRACKER_HOLDOFF_EN
        // hit sampled at edge N; now just after N.
        cyc(); cyc();
        start = 1'b1; cyc(); start = 1'b0;
        check("hold_start_n3", playing, 0);
        repeat (5) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        check("hold_start_n9", playing, 0);
        start = 1'b1; cyc(); start = 1'b0;
        check("hold_start_n10", playing, 1);
        check("hold_score0", score, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
